enc_word_deserializer: RTL and testbench

Receive-side counterpart to the encrypted-word serializer. Accepts the 78-bit encrypted word as a stream of 6-bit symbols over a valid/ready handshake, reassembles it MSB-first, and presents the complete word on a single-entry output buffer that feeds the decrypter input of the solver datapath. Detects framing errors. Optionally verifies an XOR checksum symbol.

---
 rtl/enc_rx_pkg.sv | 16 +
 rtl/enc_word_deserializer_if.sv | 25 ++
 rtl/enc_sym_shift.sv | 59 +++++
 rtl/enc_word_deserializer.sv | 155 +++++++++++++++
 tb/tb_enc_word_deserializer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/enc_rx_pkg.sv
// Shared constants and FSM state encoding for the encrypted-word receive path.
package enc_rx_pkg;

    localparam int unsigned SYM_W  = 6;
    localparam int unsigned WORD_W = 78;
    localparam int unsigned BEATS  = WORD_W / SYM_W;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/enc_word_deserializer_if.sv
// Symbol-in / word-out handshake bundle of the encrypted-word deserializer.
interface enc_word_deserializer_if #(
    parameter int unsigned SYM_W  = enc_rx_pkg::SYM_W,
    parameter int unsigned WORD_W = enc_rx_pkg::WORD_W
);
    logic [SYM_W-1:0]  sym_in;
    logic              sym_valid;
    logic              sym_sof;
    logic              sym_ready;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic              frame_err;
    logic              csum_err;

    modport master (
        output sym_in, sym_valid, sym_sof, word_ready,
        input  sym_ready, word_out, word_valid, frame_err, csum_err
    );

    modport slave (
        input  sym_in, sym_valid, sym_sof, word_ready,
        output sym_ready, word_out, word_valid, frame_err, csum_err
    );
endinterface

// File: rtl/enc_sym_shift.sv
// Symbol shift register, saturating beat counter and (ENC_RX_CHECKSUM_EN) XOR accumulator.
module enc_sym_shift #(
    parameter int unsigned SYM_W  = enc_rx_pkg::SYM_W,
    parameter int unsigned WORD_W = enc_rx_pkg::WORD_W,
    parameter int unsigned CNT_W  = enc_rx_pkg::CNT_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic              i_clear,
    input  logic [SYM_W-1:0]  i_sym,
`ifdef ENC_RX_CHECKSUM_EN
    output logic [SYM_W-1:0]  o_acc,
`endif
    output logic [WORD_W-1:0] o_word,
    output logic [CNT_W-1:0]  o_count
);
    localparam int unsigned BEATS = WORD_W / SYM_W;

    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_count;

    // Load starts a new frame; shift appends MSB-first; clear only rewinds the count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_word  <= WORD_W'(i_sym);
            r_count <= CNT_W'(1);
        end else if (i_shift) begin
            r_word  <= {r_word[WORD_W-SYM_W-1:0], i_sym};
            r_count <= (r_count == CNT_W'(BEATS)) ? r_count : r_count + CNT_W'(1);
        end else if (i_clear) begin
            r_count <= '0;
        end
    end

`ifdef ENC_RX_CHECKSUM_EN
    logic [SYM_W-1:0] r_acc;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_sym;
        end else if (i_shift) begin
            r_acc <= r_acc ^ i_sym;
        end
    end

    assign o_acc = r_acc;
`endif

    assign o_word  = r_word;
    assign o_count = r_count;

endmodule

// File: rtl/enc_word_deserializer.sv
// Reassembles 13 six-bit symbols into a 78-bit word with framing checks.
// Optional checksum beat verification when ENC_RX_CHECKSUM_EN is defined.
module enc_word_deserializer #(
    parameter int unsigned SYM_W  = enc_rx_pkg::SYM_W,
    parameter int unsigned WORD_W = enc_rx_pkg::WORD_W
) (
    input  logic                    Clk,
    input  logic                    Rst,
    enc_word_deserializer_if.slave  bus
);
    import enc_rx_pkg::*;

    localparam int unsigned BEATS = WORD_W / SYM_W;

    state_t            r_state;
    state_t            w_next;
    logic              r_sym_ready;
    logic              r_word_valid;
    logic              r_frame_err;
    logic              w_beat;
    logic              w_load;
    logic              w_shift;
    logic              w_clear;
    logic              w_frame_err;
    logic [CNT_W-1:0]  w_count;
    logic [WORD_W-1:0] w_word;
`ifdef ENC_RX_CHECKSUM_EN
    logic              r_csum_err;
    logic              w_csum_err;
    logic [SYM_W-1:0]  w_acc;
`endif

    assign w_beat = bus.sym_valid && r_sym_ready;

    enc_sym_shift #(
        .SYM_W  (SYM_W),
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_shift (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .i_sym   (bus.sym_in),
`ifdef ENC_RX_CHECKSUM_EN
        .o_acc   (w_acc),
`endif
        .o_word  (w_word),
        .o_count (w_count)
    );

    // Next-state and datapath control.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        w_frame_err = 1'b0;
`ifdef ENC_RX_CHECKSUM_EN
        w_csum_err  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_beat) begin
                    if (bus.sym_sof) begin
                        w_load = 1'b1;
                        w_next = COLLECT;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (w_beat) begin
                    if (bus.sym_sof) begin
                        w_load      = 1'b1;
                        w_frame_err = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                        if (w_count == CNT_W'(BEATS - 1)) begin
`ifdef ENC_RX_CHECKSUM_EN
                            w_next = CHECK;
`else
                            w_next = HOLD;
`endif
                        end
                    end
                end
            end
`ifdef ENC_RX_CHECKSUM_EN
            CHECK: begin
                if (w_beat) begin
                    if (bus.sym_sof) begin
                        w_load      = 1'b1;
                        w_frame_err = 1'b1;
                        w_next      = COLLECT;
                    end else if (bus.sym_in == w_acc) begin
                        w_next = HOLD;
                    end else begin
                        w_csum_err = 1'b1;
                        w_clear    = 1'b1;
                        w_next     = IDLE;
                    end
                end
            end
`endif
            HOLD: begin
                if (bus.word_ready) begin
                    w_clear = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: begin
                w_clear = 1'b1;
                w_next  = IDLE;
            end
        endcase
    end

    // State and registered handshake/status outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_sym_ready  <= 1'b0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_sym_ready  <= (w_next != HOLD);
            r_word_valid <= (w_next == HOLD);
            r_frame_err  <= w_frame_err;
        end
    end

`ifdef ENC_RX_CHECKSUM_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_csum_err <= 1'b0;
        end else begin
            r_csum_err <= w_csum_err;
        end
    end

    assign bus.csum_err = r_csum_err;
`else
    assign bus.csum_err = 1'b0;
`endif

    assign bus.sym_ready  = r_sym_ready;
    assign bus.word_valid = r_word_valid;
    assign bus.word_out   = w_word;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_enc_word_deserializer.sv
// Scoreboard bench for enc_word_deserializer; honours ENC_RX_CHECKSUM_EN like the RTL.
module tb_enc_word_deserializer;
    import enc_rx_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    enc_word_deserializer_if bus ();

    enc_word_deserializer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks      = 0;
    int n_errors      = 0;
    int words_seen    = 0;
    int words_pushed  = 0;
    int frame_err_cnt = 0;
    int csum_err_cnt  = 0;
    logic [WORD_W-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] build_word(input int base);
        logic [WORD_W-1:0] w = '0;
        for (int i = 0; i < BEATS; i++) w = {w[WORD_W-SYM_W-1:0], SYM_W'(base + i)};
        return w;
    endfunction

    function automatic logic [SYM_W-1:0] build_csum(input int base);
        logic [SYM_W-1:0] c = '0;
        for (int i = 0; i < BEATS; i++) c = c ^ SYM_W'(base + i);
        return c;
    endfunction

    task automatic push_word(input int base);
        sb_q.push_back(build_word(base));
        words_pushed++;
    endtask

    // Output monitor: pops the scoreboard on each word handshake, counts error pulses.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (bus.frame_err) frame_err_cnt++;
            if (bus.csum_err)  csum_err_cnt++;
            if (bus.word_valid && bus.word_ready) begin
                words_seen++;
                if (sb_q.size() == 0) chk("sb_underflow", 80'(sb_q.size()), 80'(1));
                else chk("word_out", 80'(bus.word_out), 80'(sb_q.pop_front()));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
    task automatic send_beat(input logic [SYM_W-1:0] s, input logic sof);
        int n = 0;
        bus.sym_in    = s;
        bus.sym_valid = 1'b1;
        bus.sym_sof   = sof;
        @(negedge Clk);
        while (!bus.sym_ready && n < 50) begin
            n++;
            @(negedge Clk);
        end
        if (n >= 50) chk("beat_timeout", 80'(n), 80'(0));
        @(posedge Clk);
        #1;
        bus.sym_valid = 1'b0;
        bus.sym_sof   = 1'b0;
    endtask

    task automatic send_data(input int base, input int nbeats);
        for (int i = 0; i < nbeats; i++) send_beat(SYM_W'(base + i), (i == 0));
    endtask

    task automatic send_frame(input int base);
        send_data(base, BEATS);
`ifdef ENC_RX_CHECKSUM_EN
        send_beat(build_csum(base), 1'b0);
`endif
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int fe0;
        int cs0;
        logic [WORD_W-1:0] held;
        bus.sym_in     = '0;
        bus.sym_valid  = 1'b0;
        bus.sym_sof    = 1'b0;
        bus.word_ready = 1'b1;

        // Reset values
        tick();
        chk("rst_sym_ready",  80'(bus.sym_ready),  80'(0));
        chk("rst_word_valid", 80'(bus.word_valid), 80'(0));
        chk("rst_word_out",   80'(bus.word_out),   80'(0));
        chk("rst_frame_err",  80'(bus.frame_err),  80'(0));
        chk("rst_csum_err",   80'(bus.csum_err),   80'(0));
        Rst = 1'b0;
        tick();
        chk("idle_sym_ready", 80'(bus.sym_ready), 80'(1));

        // Basic frame, downstream always ready
        push_word(0);
        send_frame(0);
        chk("lat_word_valid", 80'(bus.word_valid), 80'(1));
        chk("lat_word_out",   80'(bus.word_out),   80'(build_word(0)));
        tick();

        // Back-pressure: word held for 5 cycles
        bus.word_ready = 1'b0;
        push_word(0);
        send_frame(0);
        held = build_word(0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 80'(bus.word_valid), 80'(1));
            chk("hold_ready", 80'(bus.sym_ready),  80'(0));
            chk("hold_word",  80'(bus.word_out),   80'(held));
            tick();
        end
        bus.word_ready = 1'b1;
        tick();
        chk("rel_sym_ready",  80'(bus.sym_ready),  80'(1));
        chk("rel_word_valid", 80'(bus.word_valid), 80'(0));

        // Non-SOF beats in IDLE
        fe0 = frame_err_cnt;
        send_beat(6'd5, 1'b0);
        chk("fe_pulse", 80'(bus.frame_err), 80'(1));
        send_beat(6'd6, 1'b0);
        send_beat(6'd7, 1'b0);
        push_word(10);
        send_frame(10);
        tick();
        chk("fe_idle_count", 80'(frame_err_cnt - fe0), 80'(3));

        // SOF at beat 7 restarts the frame
        fe0 = frame_err_cnt;
        send_data(20, 7);
        push_word(40);
        send_frame(40);
        tick();
        chk("fe_midframe_count", 80'(frame_err_cnt - fe0), 80'(1));

`ifdef ENC_RX_CHECKSUM_EN
        // Checksum good then bad
        cs0 = csum_err_cnt;
        push_word(0);
        send_data(0, BEATS);
        send_beat(6'h0C, 1'b0);
        chk("csum_ok_valid", 80'(bus.word_valid), 80'(1));
        chk("csum_ok_err",   80'(bus.csum_err),   80'(0));
        tick();
        send_data(0, BEATS);
        send_beat(6'h0D, 1'b0);
        chk("csum_bad_err",   80'(bus.csum_err),   80'(1));
        chk("csum_bad_valid", 80'(bus.word_valid), 80'(0));
        chk("csum_bad_idle",  80'(bus.sym_ready),  80'(1));
        tick();
        chk("csum_err_count", 80'(csum_err_cnt - cs0), 80'(1));
`endif

        // Reset mid-frame, then a clean frame
        fe0 = frame_err_cnt;
        cs0 = csum_err_cnt;
        send_data(30, 6);
        Rst = 1'b1;
        tick();
        chk("midrst_sym_ready",  80'(bus.sym_ready),  80'(0));
        chk("midrst_word_valid", 80'(bus.word_valid), 80'(0));
        Rst = 1'b0;
        tick();
        chk("postrst_sym_ready", 80'(bus.sym_ready), 80'(1));
        push_word(50);
        send_frame(50);
        tick();
        tick();
        chk("rst_no_frame_err", 80'(frame_err_cnt - fe0), 80'(0));
        chk("rst_no_csum_err",  80'(csum_err_cnt - cs0),  80'(0));

        repeat (3) tick();
        chk("words_seen", 80'(words_seen), 80'(words_pushed));
        chk("sb_empty",   80'(sb_q.size()), 80'(0));
`ifdef ENC_RX_CHECKSUM_EN
        chk("csum_total", 80'(csum_err_cnt), 80'(1));
`else
        chk("csum_total", 80'(csum_err_cnt), 80'(0));
`endif
        chk("fe_total", 80'(frame_err_cnt), 80'(4));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
